// File: rtl/lvds_capture.sv
// lvds_capture: packs synchronised 4-bit LVDS samples MSB-first into 32-bit words and fills two ping-pong buffers.
// Optional macro LVDS_CAPTURE_SYNC_EN adds a SYNC_WORD hunt before filling; without it alignment is the first nibble after arming.
module lvds_capture #(
    parameter int unsigned BUFFER_BITS = 4096,
    parameter logic [31:0] SYNC_WORD   = 32'hA5A5_5A5A,
    parameter int unsigned OVF_WIDTH   = 16,
    localparam int unsigned WORDS      = BUFFER_BITS / 32,
    localparam int unsigned IW         = $clog2(WORDS)
) (
    input  logic                 S_AXI_ACLK,
    input  logic                 S_AXI_ARESETN,
    input  logic [3:0]           sample_in,
    input  logic                 sample_valid,
    input  logic                 arm,
    input  logic [1:0]           buf_release,
    output logic                 wr_en,
    output logic [IW:0]          wr_addr,
    output logic [31:0]          wr_data,
    output logic [1:0]           buf_ready,
    output logic [OVF_WIDTH-1:0] overflow_cnt,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HUNT  = 2'd1,
        ST_FILL  = 2'd2,
        ST_STALL = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             nib_q;
    logic [31:0]            shift_q;
    logic [IW-1:0]          word_idx_q;
    logic                   sel_q;
    logic                   pend_q;
    logic [1:0]             buf_ready_q, buf_ready_d;
    logic [OVF_WIDTH-1:0]   ovf_q;
    logic                   wr_en_q;
    logic [IW:0]            wr_addr_q;
    logic [31:0]            wr_data_q;

    logic [31:0]            new_word_s;
    logic                   flush_s, take_s, write_s, drop_s, last_s;
    logic [1:0]             set_mask_s;
`ifdef LVDS_CAPTURE_SYNC_EN
    logic                   sync_hit_s;
`else
    logic                   unused_sync_s;
    assign unused_sync_s = ^{SYNC_WORD, shift_q[31:28]};
`endif

    // State register
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the FILL->STALL check looks at the ready flags as they will be after this edge
    always_comb begin
        state_d = state_q;
        if (!arm) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
`ifdef LVDS_CAPTURE_SYNC_EN
                ST_IDLE: state_d = ST_HUNT;
                ST_HUNT: begin
                    if (sync_hit_s) begin
                        state_d = ST_FILL;
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
`else
                ST_IDLE: state_d = ST_FILL;
                ST_HUNT: state_d = ST_IDLE;
`endif
                ST_FILL: begin
                    if (pend_q && buf_ready_d[sel_q]) begin
                        state_d = ST_STALL;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
                ST_STALL: begin
                    if (!buf_ready_q[sel_q] && (nib_q == 3'd0)) begin
                        state_d = ST_FILL;
                    end else begin
                        state_d = ST_STALL;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output/control decode from the current state
    always_comb begin
        new_word_s = {shift_q[27:0], sample_in};
        flush_s    = !arm || (state_q == ST_IDLE);
        take_s     = sample_valid && !flush_s;
        write_s    = 1'b0;
        drop_s     = 1'b0;
`ifdef LVDS_CAPTURE_SYNC_EN
        sync_hit_s = 1'b0;
`endif
        case (state_q)
`ifdef LVDS_CAPTURE_SYNC_EN
            ST_HUNT:  sync_hit_s = take_s && (new_word_s == SYNC_WORD);
`endif
            ST_FILL:  write_s = take_s && (nib_q == 3'd7);
            ST_STALL: drop_s  = take_s && (nib_q == 3'd7);
            default:  write_s = 1'b0;
        endcase
        last_s      = write_s && (&word_idx_q);
        set_mask_s  = {pend_q & ~sel_q, pend_q & sel_q};
        buf_ready_d = (buf_ready_q & ~buf_release) | set_mask_s;
    end

    // Nibble packing; the shifter keeps running in STALL so the word boundary is never lost
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN || flush_s) begin
            nib_q      <= 3'd0;
            shift_q    <= 32'd0;
            word_idx_q <= '0;
        end else if (take_s) begin
            shift_q <= new_word_s;
            if (state_q == ST_HUNT) begin
                nib_q <= 3'd0;
            end else begin
                nib_q <= nib_q + 3'd1;
            end
            if (write_s) begin
                word_idx_q <= word_idx_q + IW'(1);
            end
        end
    end

    // Buffer ownership and drop counting; ready is set a cycle after the last word's write strobe
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            sel_q       <= 1'b0;
            pend_q      <= 1'b0;
            buf_ready_q <= 2'b00;
            ovf_q       <= '0;
        end else begin
            pend_q      <= last_s;
            buf_ready_q <= buf_ready_d;
            if (last_s) begin
                sel_q <= ~sel_q;
            end
            if (drop_s && !(&ovf_q)) begin
                ovf_q <= ovf_q + OVF_WIDTH'(1);
            end
        end
    end

    // Registered RAM write port
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 32'd0;
        end else begin
            wr_en_q <= write_s;
            if (write_s) begin
                wr_addr_q <= {sel_q, word_idx_q};
                wr_data_q <= new_word_s;
            end
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign buf_ready    = buf_ready_q;
    assign overflow_cnt = ovf_q;
    assign state        = state_q;

endmodule

// File: tb/tb_lvds_capture.sv
// Self-checking bench for lvds_capture: directed steps with random payload words, compared against
// expectations derived from the packing / ping-pong buffer rules.
module tb_lvds_capture;

    localparam int WORDS = 128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  sample_in;
    logic        sample_valid;
    logic        arm;
    logic [1:0]  buf_release;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  buf_ready;
    logic [15:0] overflow_cnt;
    logic [1:0]  state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit auto_rel = 1'b0;
    bit saw_hunt = 1'b0;

    logic [7:0]  obs_addr[$];
    logic [31:0] obs_data[$];
    int          obs_cyc[$];
    logic [1:0]  rdy_hist[$];
    int          rdy_cyc[$];
    logic [1:0]  prev_rdy = 2'b00;
    logic [7:0]  exp_addr[$];
    logic [31:0] exp_data[$];

    lvds_capture #(
        .BUFFER_BITS(4096),
        .SYNC_WORD(32'hA5A5_5A5A),
        .OVF_WIDTH(16)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESETN(rst_n),
        .sample_in(sample_in),
        .sample_valid(sample_valid),
        .arm(arm),
        .buf_release(buf_release),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .buf_ready(buf_ready),
        .overflow_cnt(overflow_cnt),
        .state(state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe writes, ready-flag changes and the HUNT encoding on the falling edge
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            obs_addr.push_back(wr_addr);
            obs_data.push_back(wr_data);
            obs_cyc.push_back(cyc);
        end
        if (buf_ready !== prev_rdy) begin
            rdy_hist.push_back(buf_ready);
            rdy_cyc.push_back(cyc);
            prev_rdy = buf_ready;
        end
        if (state === 2'd1) saw_hunt = 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; also acts as the prompt reader when auto_rel is set
    task automatic tick();
        @(posedge clk);
        #1;
        if (buf_release != 2'b00) buf_release = 2'b00;
        else if (auto_rel && buf_ready != 2'b00) buf_release = buf_ready;
        else buf_release = 2'b00;
    endtask

    task automatic clear_obs();
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
        rdy_hist.delete(); rdy_cyc.delete();
        exp_addr.delete(); exp_data.delete();
    endtask

    task automatic send_nib(input logic [3:0] n);
        sample_in    = n;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                sample_in = 4'($urandom);
                tick();
            end
            send_nib(w[31-4*i -: 4]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"},   64'(wr_en),        64'(1'b0));
        check({tag, "_wr_addr"}, 64'(wr_addr),      64'(8'd0));
        check({tag, "_wr_data"}, 64'(wr_data),      64'(32'd0));
        check({tag, "_ready"},   64'(buf_ready),    64'(2'b00));
        check({tag, "_ovf"},     64'(overflow_cnt), 64'(16'd0));
        check({tag, "_state"},   64'(state),        64'(2'd0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; arm = 1'b0; sample_valid = 1'b0; sample_in = 4'h0;
        buf_release = 2'b00; auto_rel = 1'b0;
        tick(); tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();
        clear_obs();
    endtask

    task automatic start_capture();
        logic [31:0] sw;
        arm = 1'b1;
        tick();
`ifdef LVDS_CAPTURE_SYNC_EN
        check("arm_to_hunt", 64'(state), 64'(2'd1));
        sw = 32'hA5A5_5A5A;
        for (int i = 0; i < 8; i++) send_nib(sw[31-4*i -: 4]);
`endif
        check("armed_fill", 64'(state), 64'(2'd2));
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_count"}, 64'(obs_addr.size()), 64'(exp_addr.size()));
        for (int k = 0; k < exp_addr.size() && k < obs_addr.size(); k++) begin
            check({tag, "_addr"}, 64'(obs_addr[k]), 64'(exp_addr[k]));
            check({tag, "_data"}, 64'(obs_data[k]), 64'(exp_data[k]));
        end
    endtask

    initial begin
        logic [31:0] w;
        int last_nib_cyc;

        // Reset values
        do_reset();

        // Single word: nibbles 1..8 pack to 0x12345678 at address 0
        start_capture();
        for (int i = 1; i <= 8; i++) send_nib(4'(i));
        last_nib_cyc = cyc;
        tick(); tick(); tick();
        exp_addr.push_back(8'd0); exp_data.push_back(32'h1234_5678);
        check_writes("single");
        if (obs_cyc.size() > 0) check("single_latency", 64'(obs_cyc[0]), 64'(last_nib_cyc));
        else check("single_latency", 64'(0), 64'(last_nib_cyc));

        // Ping-pong handover with a prompt reader and random sample gaps
        do_reset();
        start_capture();
        auto_rel = 1'b1;
        for (int k = 0; k < 2 * WORDS; k++) begin
            w = $urandom;
            exp_data.push_back(w);
            exp_addr.push_back(8'(((k / WORDS) % 2) * WORDS + (k % WORDS)));
            send_word(w, 1'b1);
        end
        for (int i = 0; i < 6; i++) tick();
        check_writes("pingpong");
        check("pp_ready_events", 64'(rdy_hist.size()), 64'(4));
        if (rdy_hist.size() == 4 && obs_cyc.size() == 2 * WORDS) begin
            check("pp_ready0", 64'(rdy_hist[0]), 64'(2'b01));
            check("pp_ready1", 64'(rdy_hist[1]), 64'(2'b00));
            check("pp_ready2", 64'(rdy_hist[2]), 64'(2'b10));
            check("pp_ready3", 64'(rdy_hist[3]), 64'(2'b00));
            check("pp_ready0_time", 64'(rdy_cyc[0]), 64'(obs_cyc[WORDS-1] + 1));
            check("pp_ready2_time", 64'(rdy_cyc[2]), 64'(obs_cyc[2*WORDS-1] + 1));
        end
        check("pp_ovf", 64'(overflow_cnt), 64'(16'd0));

        // Disarm after three nibbles: no write, IDLE next cycle, clean restart on re-arm
        do_reset();
        start_capture();
        w = $urandom;
        for (int i = 0; i < 3; i++) send_nib(w[31-4*i -: 4]);
        arm = 1'b0;
        send_nib(w[19:16]);
        check("disarm_idle", 64'(state), 64'(2'd0));
        for (int i = 0; i < 6; i++) send_nib(4'($urandom));
        check("disarm_no_write", 64'(obs_addr.size()), 64'(0));
        start_capture();
        w = $urandom;
        send_word(w, 1'b0);
        tick(); tick();
        exp_addr.push_back(8'd0); exp_data.push_back(w);
        check_writes("rearm");

        // Both buffers full with no release: 5 words dropped, then resume in buffer 0
        do_reset();
        start_capture();
        for (int k = 0; k < 2 * WORDS + 5; k++) begin
            w = $urandom;
            if (k < 2 * WORDS) begin
                exp_data.push_back(w);
                exp_addr.push_back(8'(k));
            end
            send_word(w, 1'b0);
        end
        tick();
        check_writes("stall_fill");
        check("stall_state", 64'(state), 64'(2'd3));
        check("stall_ovf", 64'(overflow_cnt), 64'(16'd5));
        check("stall_ready", 64'(buf_ready), 64'(2'b11));
        buf_release = 2'b01;
        tick();
        check("release_ready", 64'(buf_ready), 64'(2'b10));
        tick();
        check("resume_fill", 64'(state), 64'(2'd2));
        clear_obs();
        w = $urandom;
        send_word(w, 1'b0);
        tick(); tick();
        exp_addr.push_back(8'd0); exp_data.push_back(w);
        check_writes("resume");
        check("resume_ovf", 64'(overflow_cnt), 64'(16'd5));

        // Reset while filling with buffer 0 ready and a write strobe in flight
        do_reset();
        start_capture();
        for (int k = 0; k < WORDS + 1; k++) send_word($urandom, 1'b0);
        check("mid_ready", 64'(buf_ready), 64'(2'b01));
        check("mid_state", 64'(state), 64'(2'd2));
        check("mid_wr_en", 64'(wr_en), 64'(1'b1));
        rst_n = 1'b0;
        sample_valid = 1'b1;
        tick();
        check_reset_outputs("midreset");
        sample_valid = 1'b0;
        rst_n = 1'b1;
        tick();

`ifdef LVDS_CAPTURE_SYNC_EN
        check("hunt_seen", 64'(saw_hunt), 64'(1'b1));
`else
        check("hunt_never", 64'(saw_hunt), 64'(1'b0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
